// File: rtl/fwd_unit.sv
// fwd_unit: operand-forwarding and load-use hazard controller for the 16-bit pipeline.
//
// Tracks the destination registers of the instructions in EX and MEM and
// produces registered 3:1 operand-mux selects for EX. Stalls decode on a
// load-use hazard and keeps a saturating count of stall cycles.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   id_valid            ID-stage instruction is real (not a bubble)
//   id_rs1, id_rs2      ID-stage source registers (operand A / operand B)
//   id_rd, id_wen       ID-stage destination register and its write enable
//   id_is_load          ID-stage instruction is a memory load
//   flush               squash the ID-stage instruction (branch taken)
//   sel_a, sel_b        registered selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall               combinational decode stall (hold PC/IF-ID, bubble EX)
//   stall_cnt           saturating count of cycles with stall = 1
module fwd_unit #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             flush,
    output logic [1:0]       sel_a,
    output logic [1:0]       sel_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelEx  = 2'b01;
    localparam logic [1:0] SelMem = 2'b10;

    // Instruction currently in EX.
    logic             ex_valid;
    logic [REG_W-1:0] ex_rd;
    logic             ex_wen;
    logic             ex_load;

    // Instruction currently in MEM.
    logic             mem_valid;
    logic [REG_W-1:0] mem_rd;
    logic             mem_wen;

    logic hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic [1:0] sel_a_d, sel_b_d;
    logic bubble;

    always_comb begin
        // R0 is hard-wired zero, so it never takes a forwarded value.
        hit_ex_a  = ex_valid  & ex_wen  & (ex_rd  == id_rs1) & (id_rs1 != '0);
        hit_ex_b  = ex_valid  & ex_wen  & (ex_rd  == id_rs2) & (id_rs2 != '0);
        hit_mem_a = mem_valid & mem_wen & (mem_rd == id_rs1) & (id_rs1 != '0);
        hit_mem_b = mem_valid & mem_wen & (mem_rd == id_rs2) & (id_rs2 != '0);

        // Youngest producer wins: EX takes priority over MEM.
        sel_a_d = hit_ex_a ? SelEx : (hit_mem_a ? SelMem : SelRf);
        sel_b_d = hit_ex_b ? SelEx : (hit_mem_b ? SelMem : SelRf);

        // A load's data is not ready until after MEM, so an immediate consumer waits one cycle.
        stall = id_valid & ex_valid & ex_load & ex_wen & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (ex_rd == id_rs2));

        bubble = flush | stall | ~id_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_rd     <= '0;
            ex_wen    <= 1'b0;
            ex_load   <= 1'b0;
            mem_valid <= 1'b0;
            mem_rd    <= '0;
            mem_wen   <= 1'b0;
            sel_a     <= SelRf;
            sel_b     <= SelRf;
            stall_cnt <= '0;
        end else begin
            // MEM always advances; a stall only freezes the front of the pipe.
            mem_valid <= ex_valid;
            mem_rd    <= ex_rd;
            mem_wen   <= ex_wen;

            if (bubble) begin
                ex_valid <= 1'b0;
                sel_a    <= SelRf;
                sel_b    <= SelRf;
            end else begin
                ex_valid <= id_valid;
                ex_rd    <= id_rd;
                ex_wen   <= id_wen;
                ex_load  <= id_is_load;
                sel_a    <= sel_a_d;
                sel_b    <= sel_b_d;
            end

            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_unit.sv
// tb_fwd_unit: directed and randomized checks of fwd_unit against a pipeline-history model.
module tb_fwd_unit;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [3:0]    id_rs1;
    logic [3:0]    id_rs2;
    logic [3:0]    id_rd;
    logic          id_wen;
    logic          id_is_load;
    logic          flush;
    logic [1:0]    sel_a;
    logic [1:0]    sel_b;
    logic          stall;
    logic [CW-1:0] stall_cnt;

    fwd_unit #(
        .REG_W(4),
        .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .id_rd     (id_rd),
        .id_wen    (id_wen),
        .id_is_load(id_is_load),
        .flush     (flush),
        .sel_a     (sel_a),
        .sel_b     (sel_b),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: list of in-flight instructions, index 0 = one ahead of ID (EX), 1 = two ahead (MEM).
    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       wen;
        logic       load;
    } inst_t;

    inst_t      ahead [2];
    logic [1:0] exp_sa;
    logic [1:0] exp_sb;
    int         exp_cnt;
    logic       obs_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Nearest in-flight writer of r supplies the value; distance 1 -> 01, distance 2 -> 10.
    function automatic logic [1:0] ref_sel(input logic [3:0] r);
        for (int d = 0; d < 2; d++) begin
            if (r != 0 && ahead[d].valid && ahead[d].wen && ahead[d].rd == r) begin
                return (d == 0) ? 2'b01 : 2'b10;
            end
        end
        return 2'b00;
    endfunction

    // A load one ahead cannot feed the reader yet.
    function automatic logic ref_stall(input logic v, input logic [3:0] r1, input logic [3:0] r2);
        return v && ahead[0].valid && ahead[0].load && ahead[0].wen && ahead[0].rd != 0 &&
               (ahead[0].rd == r1 || ahead[0].rd == r2);
    endfunction

    task automatic model_reset();
        ahead[0] = '0;
        ahead[1] = '0;
        exp_sa   = 2'b00;
        exp_sb   = 2'b00;
        exp_cnt  = 0;
    endtask

    task automatic step(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] rd, input logic wen, input logic ld,
                        input logic fl, input string tag);
        logic  es;
        inst_t nxt;
        id_valid   = v;
        id_rs1     = r1;
        id_rs2     = r2;
        id_rd      = rd;
        id_wen     = wen;
        id_is_load = ld;
        flush      = fl;
        #1;
        es        = ref_stall(v, r1, r2);
        obs_stall = stall;
        chk({tag, ".stall"}, {15'd0, stall}, {15'd0, es});
        if (fl || es || !v) begin
            nxt    = '0;
            exp_sa = 2'b00;
            exp_sb = 2'b00;
        end else begin
            nxt    = '{valid: 1'b1, rd: rd, wen: wen, load: ld};
            exp_sa = ref_sel(r1);
            exp_sb = ref_sel(r2);
        end
        ahead[1] = ahead[0];
        ahead[0] = nxt;
        if (es && exp_cnt < CMAX) exp_cnt++;
        @(posedge clk);
        #1;
        chk({tag, ".sel_a"}, {14'd0, sel_a}, {14'd0, exp_sa});
        chk({tag, ".sel_b"}, {14'd0, sel_b}, {14'd0, exp_sb});
        chk({tag, ".cnt"}, 16'(stall_cnt), 16'(exp_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_wen = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_wen = 1'b0; id_is_load = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        chk("rst.sel_a", {14'd0, sel_a}, 16'd0);
        chk("rst.sel_b", {14'd0, sel_b}, 16'd0);
        chk("rst.stall", {15'd0, stall}, 16'd0);
        chk("rst.cnt", 16'(stall_cnt), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back dependence: ADD R3 then reader of R3/R5.
        step(1, 0, 0, 3, 1, 0, 0, "b2b.add");
        step(1, 3, 5, 9, 0, 0, 0, "b2b.use");
        chk("b2b.sel_a", {14'd0, sel_a}, 16'd1);
        chk("b2b.sel_b", {14'd0, sel_b}, 16'd0);

        // Two writers of R4: EX copy wins.
        step(1, 0, 0, 4, 1, 0, 0, "prio.w1");
        step(1, 0, 0, 4, 1, 0, 0, "prio.w2");
        step(1, 4, 4, 9, 0, 0, 0, "prio.use");
        chk("prio.sel_a", {14'd0, sel_a}, 16'd1);
        chk("prio.sel_b", {14'd0, sel_b}, 16'd1);

        // Distance-2 only.
        step(1, 0, 0, 4, 1, 0, 0, "d2.w1");
        step(1, 0, 0, 7, 1, 0, 0, "d2.w2");
        step(1, 4, 4, 9, 0, 0, 0, "d2.use");
        chk("d2.sel_a", {14'd0, sel_a}, 16'd2);
        chk("d2.sel_b", {14'd0, sel_b}, 16'd2);

        // Load-use: one bubble, then MEM/WB forwarding.
        do_reset();
        step(1, 0, 0, 2, 1, 1, 0, "lu.load");
        step(1, 8, 2, 10, 1, 0, 0, "lu.use0");
        chk("lu.stall0", {15'd0, obs_stall}, 16'd1);
        chk("lu.bubble_sel_b", {14'd0, sel_b}, 16'd0);
        step(1, 8, 2, 10, 1, 0, 0, "lu.use1");
        chk("lu.stall1", {15'd0, obs_stall}, 16'd0);
        chk("lu.sel_b", {14'd0, sel_b}, 16'd2);
        chk("lu.cnt", 16'(stall_cnt), 16'd1);

        // R0 and non-writers never forward.
        step(1, 0, 0, 0, 1, 0, 0, "r0.w");
        step(1, 0, 9, 11, 0, 0, 0, "r0.use");
        chk("r0.sel_a", {14'd0, sel_a}, 16'd0);
        step(1, 0, 0, 6, 0, 0, 0, "nw.w");
        step(1, 6, 9, 11, 0, 0, 0, "nw.use");
        chk("nw.sel_a", {14'd0, sel_a}, 16'd0);
        step(1, 0, 0, 0, 1, 1, 0, "r0ld.load");
        step(1, 0, 0, 11, 0, 0, 0, "r0ld.use");
        chk("r0ld.stall", {15'd0, obs_stall}, 16'd0);

        // Flushed writer is never tracked.
        step(1, 0, 0, 1, 1, 0, 1, "fl.w");
        step(1, 1, 9, 11, 0, 0, 0, "fl.use");
        chk("fl.sel_a", {14'd0, sel_a}, 16'd0);

        // Reset in the middle of a stall clears everything immediately.
        step(1, 0, 0, 5, 1, 0, 0, "rs.w");
        step(1, 5, 0, 5, 1, 1, 0, "rs.load");
        chk("rs.pre_sel_a", {14'd0, sel_a}, 16'd1);
        id_valid = 1'b1; id_rs1 = 4'd5; id_rs2 = 4'd0; id_rd = 4'd12;
        id_wen = 1'b1; id_is_load = 1'b0; flush = 1'b0;
        #1;
        chk("rs.pre_stall", {15'd0, stall}, 16'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("rs.stall", {15'd0, stall}, 16'd0);
        chk("rs.sel_a", {14'd0, sel_a}, 16'd0);
        chk("rs.sel_b", {14'd0, sel_b}, 16'd0);
        chk("rs.cnt", 16'(stall_cnt), 16'd0);
        do_reset();

        // Twenty stalls against a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 2, 1, 1, 0, "sat.load");
            step(1, 2, 0, 3, 0, 0, 0, "sat.use0");
            step(1, 2, 0, 3, 0, 0, 0, "sat.use1");
        end
        chk("sat.cnt", 16'(stall_cnt), 16'd15);

        // Randomized traffic on a small register set to provoke hits.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 8), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) == 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
